mux8_to_1: RTL and testbench
============================

// Module: mux8_to_1
// PURPOSE
//   Eight-input selector: routes lane in[sel] to out. Output is registered by
//   default; it can be configured combinational for timing-free glue use.
//   Sits in datapath steering logic. A valid qualifier travels alongside the
//   data so downstream logic knows when out is meaningful.
// PARAMETERS
//   LANE_W   1   width of each of the 8 input lanes and of out
//   REG_OUT  1   1 = out/out_valid registered (1-cycle latency); 0 = combinational
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   sel        in   3          lane select, 0..7
//   in         in   8*LANE_W   packed lanes; lane k = in[k*LANE_W +: LANE_W]
//   in_valid   in   1          qualifies sel/in this cycle
//   out        out  LANE_W     selected lane
//   out_valid  out  1          qualifies out
// BEHAVIOUR
//   - One clock (clk), asynchronous active-high reset (rst); no other clocks.
//   - Selection: out = lane[sel]; sel=0 picks in[LANE_W-1:0], sel=7 picks top lane.
//     All 8 sel codes are legal; no out-of-range case exists.
//   - REG_OUT=1:
//     - on each rising clk with rst low:
//       - out <= lane[sel]
//       - out_valid <= in_valid
//     - latency exactly 1 cycle; sel/in changes mid-cycle are invisible until
//       the next edge.
//     - rst high (asserted at any time, asynchronously) forces out=0 and
//       out_valid=0 immediately; both hold 0 while rst is high.
//     - First edge after rst deasserts captures normally; no extra dead cycle.
//   - REG_OUT=0:
//     - out = lane[sel] and out_valid = in_valid, purely combinational,
//       with zero latency.
//     - rst and clk have no effect on out; out_valid is forced to 0 while
//       rst is high.
//   - out is updated regardless of in_valid; only out_valid tracks it
//     (no data gating, no hold-last-value).
//   - No X propagation from unused lanes; only the selected lane affects out.
//   - Changing in and sel on the same edge: the new pair is sampled together.
// TESTING
//   1. REG_OUT=1, LANE_W=1: rst pulse mid-run -> out=0, out_valid=0 asynchronously,
//      before the next clk edge.
//   2. in=8'b10101010, sweep sel 0..7 one per cycle, in_valid=1 ->
//      out one cycle later = 0,1,0,1,0,1,0,1; out_valid=1 throughout.
//   3. in=8'b11110000, sweep sel 0..7 -> out = 0,0,0,0,1,1,1,1
//      (1-cycle delayed).
//   4. Change in from 10101010 to 11110000 on the same edge as sel=3'b000 ->
//      next out=0, then sel=3'b100 -> 1; in_valid toggled 1,0,1 ->
//      out_valid follows 1,0,1 delayed.
//   5. LANE_W=4, in=32'h76543210, sel 0..7 -> out = 0x0..0x7.
//   6. REG_OUT=0: in=8'b10101010, sel=5 -> out=1 in the same timestep,
//      no clk edge needed.

Source files
------------

// File: rtl/mux8_to_1_if.sv
// Bundle for the 8-lane selector: request side (sel/in/in_valid) and result side (out/out_valid).
interface mux8_to_1_if #(
  parameter int unsigned LANE_W = 1
) ();
  logic [2:0]          sel;
  logic [8*LANE_W-1:0] in;
  logic                in_valid;
  logic [LANE_W-1:0]   out;
  logic                out_valid;

  modport master (
    output sel,
    output in,
    output in_valid,
    input  out,
    input  out_valid
  );

  modport slave (
    input  sel,
    input  in,
    input  in_valid,
    output out,
    output out_valid
  );
endinterface

// File: rtl/mux8_to_1.sv
// Eight-lane selector with a valid qualifier; registered (1-cycle) or combinational output.
module mux8_to_1 #(
  parameter int unsigned LANE_W  = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  mux8_to_1_if.slave bus
);

  logic [LANE_W-1:0] sel_lane;

  // Explicit compare per code so only the chosen lane can reach out.
  always_comb begin
    sel_lane = '0;
    for (int k = 0; k < 8; k++) begin
      if (bus.sel == 3'(k)) begin
        sel_lane = bus.in[k*LANE_W +: LANE_W];
      end
    end
  end

  if (REG_OUT) begin : g_reg
    logic [LANE_W-1:0] out_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= sel_lane;
        valid_q <= bus.in_valid;
      end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
  end else begin : g_comb
    // Data stays live through reset; only the qualifier is suppressed.
    assign bus.out       = sel_lane;
    assign bus.out_valid = bus.in_valid & ~rst;
  end

endmodule

// File: tb/tb_mux8_to_1.sv
// Directed plus random checks of registered (1- and 4-bit lanes) and combinational selectors.
module tb_mux8_to_1;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_r1;
  logic [31:0] exp_r4;
  logic        exp_v;

  mux8_to_1_if #(.LANE_W(1)) b1 ();
  mux8_to_1_if #(.LANE_W(4)) b4 ();
  mux8_to_1_if #(.LANE_W(1)) bc ();

  mux8_to_1 #(.LANE_W(1), .REG_OUT(1'b1)) u_r1 (.clk(clk), .rst(rst), .bus(b1));
  mux8_to_1 #(.LANE_W(4), .REG_OUT(1'b1)) u_r4 (.clk(clk), .rst(rst), .bus(b4));
  mux8_to_1 #(.LANE_W(1), .REG_OUT(1'b0)) u_c1 (.clk(clk), .rst(rst), .bus(bc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane s of a packed word is the w bits starting at bit s*w.
  function automatic logic [31:0] lane(input logic [31:0] d, input int s, input int w);
    return (d >> (s * w)) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+2; returns at the following posedge+2.
  task automatic step(input logic [2:0] s, input logic [7:0] d8, input logic [31:0] d32,
                      input logic v);
    b1.sel = s; b1.in = d8;  b1.in_valid = v;
    b4.sel = s; b4.in = d32; b4.in_valid = v;
    bc.sel = s; bc.in = d8;  bc.in_valid = v;
    #1;
    chk("comb_out", 32'(bc.out), lane(32'(d8), int'(s), 1));
    chk("comb_valid", 32'(bc.out_valid), 32'(v & ~rst));
    chk("r1_out_hold", 32'(b1.out), exp_r1);
    chk("r4_out_hold", 32'(b4.out), exp_r4);
    chk("r1_valid_hold", 32'(b1.out_valid), 32'(exp_v));
    exp_r1 = lane(32'(d8), int'(s), 1);
    exp_r4 = lane(d32, int'(s), 4);
    exp_v  = v;
    @(posedge clk);
    #2;
    chk("r1_out", 32'(b1.out), exp_r1);
    chk("r1_valid", 32'(b1.out_valid), 32'(exp_v));
    chk("r4_out", 32'(b4.out), exp_r4);
    chk("r4_valid", 32'(b4.out_valid), 32'(exp_v));
  endtask

  initial begin
    rst = 1'b1;
    exp_r1 = '0; exp_r4 = '0; exp_v = 1'b0;
    b1.sel = '0; b1.in = '0; b1.in_valid = 1'b0;
    b4.sel = '0; b4.in = '0; b4.in_valid = 1'b0;
    bc.sel = '0; bc.in = '0; bc.in_valid = 1'b0;
    #1;
    chk("rst_r1_out", 32'(b1.out), 32'd0);
    chk("rst_r1_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_r4_out", 32'(b4.out), 32'd0);
    chk("rst_comb_valid", 32'(bc.out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int s = 0; s < 8; s++) step(3'(s), 8'b1010_1010, 32'h7654_3210, 1'b1);
    for (int s = 0; s < 8; s++) step(3'(s), 8'b1111_0000, 32'h7654_3210, 1'b1);

    // New in and sel land on the same edge; valid pattern 1,0,1.
    step(3'd0, 8'b1111_0000, 32'h7654_3210, 1'b1);
    step(3'd4, 8'b1111_0000, 32'h7654_3210, 1'b0);
    step(3'd4, 8'b1111_0000, 32'h7654_3210, 1'b1);

    // Combinational lane 5 of 10101010.
    step(3'd5, 8'b1010_1010, 32'hFEDC_BA98, 1'b1);

    // Asynchronous reset mid-run, between edges.
    step(3'd2, 8'hFF, 32'hFFFF_FFFF, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_r1_out", 32'(b1.out), 32'd0);
    chk("async_r1_valid", 32'(b1.out_valid), 32'd0);
    chk("async_r4_out", 32'(b4.out), 32'd0);
    chk("async_comb_out", 32'(bc.out), 32'd1);
    chk("async_comb_valid", 32'(bc.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_r1_out", 32'(b1.out), 32'd0);
    chk("rst_hold_r1_valid", 32'(b1.out_valid), 32'd0);
    #1;
    rst = 1'b0;
    exp_r1 = '0; exp_r4 = '0; exp_v = 1'b0;

    step(3'd7, 8'h80, 32'hA000_0000, 1'b1);

    for (int i = 0; i < 40; i++) begin
      step(3'($urandom_range(0, 7)), 8'($urandom), $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
